incrementer_unit: RTL and testbench

INCREMENTER_UNIT -- requirements
Module: incrementer_unit

---
 rtl/incrementer_unit.sv | 73 +++++++
 tb/tb_incrementer_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/incrementer_unit.sv
// incrementer_unit: registered 32-bit +1 with carry-out.
// Bit ordering is [0:31] with bit 0 as MSB and bit 31 as LSB.
// The combinational adder is split into eight 4-bit groups.
// Group 7 holds bits 28-31 and is the least significant group.
// Group 0 holds bits 0-3 and is the most significant group.
// Group carries come from a lookahead AND of the lower group propagates.
// No carry ripples bit by bit across a group boundary.
module incrementer_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:31] a,
  output logic [0:31] s,
  output logic        outC
);

  logic [0:7]  gp;
  logic [0:7]  gcin;
  logic [0:31] sum_d;
  logic        carry_d;
  logic [0:31] s_q;
  logic        outC_q;

  // Group propagates: AND of the four bits in each group.
  always_comb begin
    gp = '0;
    for (int g = 0; g < 8; g++) begin
      gp[g] = a[4*g] & a[4*g+1] & a[4*g+2] & a[4*g+3];
    end
  end

  // Lookahead prefix.
  // Each group's carry-in is the flat AND of every less-significant propagate.
  // The LSB group always sees a carry-in of 1, which is the +1.
  always_comb begin
    gcin = '1;
    for (int g = 0; g < 7; g++) begin
      for (int k = g + 1; k < 8; k++) begin
        gcin[g] = gcin[g] & gp[k];
      end
    end
  end

  // In-group sum: toggle a bit when the carry-in and all lower bits of its group are 1.
  always_comb begin
    sum_d = '0;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 4; j++) begin
        logic lower_ones;
        lower_ones = 1'b1;
        for (int m = j + 1; m < 4; m++) begin
          lower_ones = lower_ones & a[4*g+m];
        end
        sum_d[4*g+j] = a[4*g+j] ^ (gcin[g] & lower_ones);
      end
    end
    carry_d = &gp;
  end

  // Output register; reset clears asynchronously and discards the sampled operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      outC_q <= 1'b0;
    end else begin
      s_q    <= sum_d;
      outC_q <= carry_d;
    end
  end

  assign s    = s_q;
  assign outC = outC_q;

endmodule

// File: tb/tb_incrementer_unit.sv
// Self-checking bench for incrementer_unit.
// Table vectors and a random sweep feed a scoreboard queue.
// Hand-written sequences cover reset and hold behaviour.
module tb_incrementer_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] s;
  logic        outC;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[8];

  incrementer_unit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .s    (s),
    .outC (outC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive the operand at negedge, then compare one posedge later.
  // The expected value comes from the bench reference model.
  task automatic apply(input logic [31:0] val, input string name);
    vec_t e;
    vec_t got;
    @(negedge clk);
    a = val;
    e.a = val;
    e.s = val + 32'd1;
    e.c = (val == 32'hFFFF_FFFF);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({name, "_s"}, s, got.s);
    chk({name, "_c"}, {31'd0, outC}, {31'd0, got.c});
    if (outC === 1'b1) chk({name, "_inv"}, s, 32'h0);
  endtask

  initial begin
    logic [31:0] held_s;
    logic        held_c;

    tbl[0] = '{32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[1] = '{32'h0000_000A, 32'h0000_000B, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[3] = '{32'h0000_FFFF, 32'h0001_0000, 1'b0};
    tbl[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0};
    tbl[5] = '{32'h0FFF_FFFF, 32'h1000_0000, 1'b0};
    tbl[6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0};
    tbl[7] = '{32'h0000_000F, 32'h0000_0010, 1'b0};

    rst = 1'b1;
    a   = 32'h1234_5678;
    #2;
    chk("reset_s", s, 32'h0);
    chk("reset_c", {31'd0, outC}, 32'd0);

    // Releasing reset between edges must not change the outputs.
    #5;
    rst = 1'b0;
    #1;
    chk("release_s", s, 32'h0);
    chk("release_c", {31'd0, outC}, 32'd0);

    // Table vectors are driven back to back.
    for (int i = 0; i < 8; i++) begin
      vec_t e;
      @(negedge clk);
      a = tbl[i].a;
      sb_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("tbl%0d_s", i), s, e.s);
      chk($sformatf("tbl%0d_c", i), {31'd0, outC}, {31'd0, e.c});
    end

    // Outputs must hold between edges even when the operand changes.
    apply(32'h0000_0041, "pre_hold");
    held_s = s;
    held_c = outC;
    a = 32'hFFFF_FFFF;
    #2;
    chk("hold_s", s, 32'h0000_0042);
    chk("hold_c", {31'd0, outC}, {31'd0, held_c});

    // Mid-stream reset clears outputs at once, with no clock edge needed.
    apply(32'hFFFF_FFFF, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_s", s, 32'h0);
    chk("midrst_c", {31'd0, outC}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrel_s", s, 32'h0);
    apply(32'h0000_0005, "after_rst");
    chk("after_rst_val", s, 32'h0000_0006);

    // Random sweep. The invariant is checked inside apply on every cycle.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] r;
      case (i % 50)
        0:       r = 32'hFFFF_FFFF;
        1:       r = 32'hFFFF_FFFF << $urandom_range(31, 1);
        default: r = $urandom;
      endcase
      apply(r, "rand");
    end

    if (sb_q.size() != 0) chk("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
